// File: rtl/parity_pkg.sv
// Shared definitions for the 4-bit parity datapath (generator and receiver).
package parity_pkg;

    localparam int unsigned DATA_W     = 4;
    localparam int unsigned FRAME_BITS = 7;
    localparam int unsigned IDX_W      = $clog2(DATA_W);

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DATA      = 3'd1,
        PARITY    = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/parity_generator_4bit.sv
// Combinational parity generator; the single definition of parity for the link.
module parity_generator_4bit
    import parity_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic              parity_mode,
    output logic              parity_c
);

    // Even mode: XOR of data; odd mode: its complement.
    always_comb begin
        parity_c = ^data;
        if (parity_mode == PARITY_ODD) begin
            parity_c = ~(^data);
        end
    end

endmodule

// File: rtl/parity_frame_receiver.sv
// Framed serial receiver: start, 4 data bits LSB first, parity, stop.
module parity_frame_receiver
    import parity_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_en,
    input  logic                 sin,
    input  logic                 parity_mode,
    input  logic                 clr_count,
    output logic [DATA_W-1:0]    data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [ERR_CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DATA_W - 1);

    rx_state_t         state;
    rx_state_t         next_state;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shift_reg;
    logic              mode_q;
    logic              rx_parity;

    logic start_c;
    logic shift_c;
    logic cap_par_c;
    logic stop_c;
    logic exp_parity_c;
    logic perr_c;
    logic ferr_c;

    parity_generator_4bit u_gen (
        .data        (shift_reg),
        .parity_mode (mode_q),
        .parity_c    (exp_parity_c)
    );

    assign perr_c = exp_parity_c ^ rx_parity;
    assign ferr_c = ~sin;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and per-strobe datapath enables.
    always_comb begin
        next_state = state;
        start_c    = 1'b0;
        shift_c    = 1'b0;
        cap_par_c  = 1'b0;
        stop_c     = 1'b0;
        if (bit_en) begin
            case (state)
                IDLE: begin
                    if (!sin) begin
                        start_c    = 1'b1;
                        next_state = DATA;
                    end
                end
                DATA: begin
                    shift_c = 1'b1;
                    if (bit_idx == LAST_IDX) begin
                        next_state = PARITY;
                    end
                end
                PARITY: begin
                    cap_par_c  = 1'b1;
                    next_state = STOP;
                end
                STOP: begin
                    stop_c     = 1'b1;
                    next_state = sin ? IDLE : WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    if (sin) begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Frame capture: bit index, data bits, received parity and latched mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx   <= '0;
            shift_reg <= '0;
            mode_q    <= PARITY_EVEN;
            rx_parity <= 1'b0;
        end else begin
            if (start_c) begin
                bit_idx <= '0;
                mode_q  <= parity_mode;
            end
            if (shift_c) begin
                shift_reg[bit_idx] <= sin;
                bit_idx            <= bit_idx + IDX_W'(1);
            end
            if (cap_par_c) begin
                rx_parity <= sin;
            end
        end
    end

    // Result registers, updated together on the stop-bit sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= stop_c;
            busy       <= (next_state != IDLE);
            if (stop_c) begin
                data_out   <= shift_reg;
                parity_err <= perr_c;
                frame_err  <= ferr_c;
            end
        end
    end

    // Saturating error counter; clear has priority over an increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (clr_count) begin
            err_count <= '0;
        end else if (stop_c && (perr_c || ferr_c) && (err_count != CNT_MAX)) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_parity_frame_receiver.sv
// Directed bench for parity_frame_receiver (default and 2-bit counter instances).
module tb_parity_frame_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_en;
    logic       sin;
    logic       parity_mode;
    logic       clr_count;

    logic [3:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;
    logic [7:0] err_count;

    logic [3:0] data_out2;
    logic       data_valid2;
    logic       parity_err2;
    logic       frame_err2;
    logic       busy2;
    logic [1:0] err_count2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    parity_frame_receiver dut (
        .clk         (clk),
        .rst         (rst),
        .bit_en      (bit_en),
        .sin         (sin),
        .parity_mode (parity_mode),
        .clr_count   (clr_count),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .busy        (busy),
        .err_count   (err_count)
    );

    parity_frame_receiver #(.ERR_CNT_W(2)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .bit_en      (bit_en),
        .sin         (sin),
        .parity_mode (parity_mode),
        .clr_count   (clr_count),
        .data_out    (data_out2),
        .data_valid  (data_valid2),
        .parity_err  (parity_err2),
        .frame_err   (frame_err2),
        .busy        (busy2),
        .err_count   (err_count2)
    );

    // One clock with the given strobe and line level; outputs sampled 1 after the edge.
    task automatic drive(input logic en, input logic s);
        bit_en = en;
        sin    = s;
        @(posedge clk);
        #1;
    endtask

    // Full frame with bit_en held high; clr applies only on the stop-bit edge.
    task automatic send_frame(input logic mode, input logic [3:0] d, input logic par,
                              input logic stop, input logic clr);
        parity_mode = mode;
        drive(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, d[i]);
        drive(1'b1, par);
        clr_count = clr;
        drive(1'b1, stop);
        clr_count = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bit_en = 1'b0; sin = 1'b1; parity_mode = 1'b0; clr_count = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (data_out !== 4'h0) begin failures++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
        checks++; if (parity_err !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", parity_err, frame_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (err_count !== 8'd0 || err_count2 !== 2'd0) begin failures++; $display("FAIL reset_err_count got=%0d/%0d exp=0/0", err_count, err_count2); end
        rst = 1'b0;
        drive(1'b0, 1'b1);
    endtask

    task automatic test_even_good();
        parity_mode = 1'b0;
        drive(1'b1, 1'b0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL even_busy_after_start got=%b exp=1", busy); end
        drive(1'b1, 1'b0); drive(1'b1, 1'b1); drive(1'b1, 1'b1); drive(1'b1, 1'b0);
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL even_early_valid got=%b exp=0", data_valid); end
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL even_valid got=%b exp=1", data_valid); end
        checks++; if (data_out !== 4'b0110) begin failures++; $display("FAIL even_data got=%b exp=0110", data_out); end
        checks++; if (parity_err !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL even_flags got=%b%b exp=00", parity_err, frame_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL even_busy_end got=%b exp=0", busy); end
        drive(1'b1, 1'b1);
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL even_valid_pulse got=%b exp=0", data_valid); end
        checks++; if (data_out !== 4'b0110) begin failures++; $display("FAIL even_data_hold got=%b exp=0110", data_out); end
        checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL even_err_count got=%0d exp=0", err_count); end
    endtask

    task automatic test_odd_parity_err();
        send_frame(1'b1, 4'b0111, 1'b1, 1'b1, 1'b0);
        checks++; if (data_valid !== 1'b1 || data_out !== 4'b0111) begin failures++; $display("FAIL odd_data got=%b/%b exp=1/0111", data_valid, data_out); end
        checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL odd_parity_err got=%b exp=1", parity_err); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL odd_frame_err got=%b exp=0", frame_err); end
        checks++; if (err_count !== 8'd1 || err_count2 !== 2'd1) begin failures++; $display("FAIL odd_err_count got=%0d/%0d exp=1/1", err_count, err_count2); end
        drive(1'b0, 1'b1);
    endtask

    task automatic test_frame_err();
        send_frame(1'b0, 4'b0110, 1'b0, 1'b0, 1'b0);
        checks++; if (data_valid !== 1'b1 || data_out !== 4'b0110) begin failures++; $display("FAIL ferr_data got=%b/%b exp=1/0110", data_valid, data_out); end
        checks++; if (frame_err !== 1'b1 || parity_err !== 1'b0) begin failures++; $display("FAIL ferr_flags got=p%b f%b exp=p0 f1", parity_err, frame_err); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ferr_busy got=%b exp=1", busy); end
        checks++; if (err_count !== 8'd2 || err_count2 !== 2'd2) begin failures++; $display("FAIL ferr_err_count got=%0d/%0d exp=2/2", err_count, err_count2); end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0);
            checks++; if (busy !== 1'b1 || data_valid !== 1'b0) begin failures++; $display("FAIL ferr_stuck_%0d busy=%b valid=%b exp=1/0", i, busy, data_valid); end
        end
        drive(1'b1, 1'b1);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_release_busy got=%b exp=0", busy); end
        drive(1'b1, 1'b1);
        checks++; if (data_valid !== 1'b0 || err_count !== 8'd2) begin failures++; $display("FAIL ferr_no_spurious valid=%b cnt=%0d exp=0/2", data_valid, err_count); end
    endtask

    task automatic test_gating_mode();
        logic [5:0] bits;
        bits = 6'b100110;
        parity_mode = 1'b0;
        drive(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            parity_mode = ~parity_mode;
            drive(1'b0, ~bits[i]);
            checks++; if (data_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL gate_hold_%0d valid=%b busy=%b exp=0/1", i, data_valid, busy); end
            parity_mode = 1'b1;
            drive(1'b1, bits[i]);
        end
        checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL gate_valid got=%b exp=1", data_valid); end
        checks++; if (data_out !== 4'b0110) begin failures++; $display("FAIL gate_data got=%b exp=0110", data_out); end
        checks++; if (parity_err !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL gate_flags got=%b%b exp=00", parity_err, frame_err); end
        checks++; if (err_count !== 8'd2) begin failures++; $display("FAIL gate_err_count got=%0d exp=2", err_count); end
        drive(1'b0, 1'b1);
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL gate_valid_pulse got=%b exp=0", data_valid); end
    endtask

    task automatic test_back_to_back();
        send_frame(1'b0, 4'b0110, 1'b0, 1'b1, 1'b0);
        checks++; if (data_valid !== 1'b1 || data_out !== 4'b0110) begin failures++; $display("FAIL b2b_first got=%b/%b exp=1/0110", data_valid, data_out); end
        drive(1'b1, 1'b0);
        checks++; if (data_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL b2b_start valid=%b busy=%b exp=0/1", data_valid, busy); end
        drive(1'b1, 1'b1); drive(1'b1, 1'b0); drive(1'b1, 1'b0); drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        checks++; if (data_valid !== 1'b1 || data_out !== 4'b1001) begin failures++; $display("FAIL b2b_second got=%b/%b exp=1/1001", data_valid, data_out); end
        checks++; if (parity_err !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL b2b_flags got=%b%b exp=00", parity_err, frame_err); end
        drive(1'b0, 1'b1);
    endtask

    task automatic test_reset_midframe();
        parity_mode = 1'b0;
        drive(1'b1, 1'b0); drive(1'b1, 1'b0); drive(1'b1, 1'b1);
        rst = 1'b1;
        #1;
        checks++; if (data_out !== 4'h0 || data_valid !== 1'b0) begin failures++; $display("FAIL rstmid_data got=%h/%b exp=0/0", data_out, data_valid); end
        checks++; if (busy !== 1'b0 || parity_err !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL rstmid_status busy=%b p=%b f=%b exp=000", busy, parity_err, frame_err); end
        checks++; if (err_count !== 8'd0 || err_count2 !== 2'd0) begin failures++; $display("FAIL rstmid_err_count got=%0d/%0d exp=0/0", err_count, err_count2); end
        drive(1'b1, 1'b1);
        rst = 1'b0;
        drive(1'b1, 1'b1);
        checks++; if (data_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_aborted valid=%b busy=%b exp=0/0", data_valid, busy); end
        send_frame(1'b0, 4'b1010, 1'b0, 1'b1, 1'b0);
        checks++; if (data_valid !== 1'b1 || data_out !== 4'b1010 || parity_err !== 1'b0) begin failures++; $display("FAIL rstmid_next got=%b/%b/%b exp=1/1010/0", data_valid, data_out, parity_err); end
        drive(1'b0, 1'b1);
    endtask

    task automatic test_saturation_clear();
        logic [7:0] exp8 [5];
        logic [1:0] exp2 [5];
        exp8 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        exp2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 5; i++) begin
            send_frame(1'b0, 4'b0001, 1'b0, 1'b1, 1'b0);
            checks++; if (err_count !== exp8[i] || err_count2 !== exp2[i]) begin failures++; $display("FAIL sat_frame_%0d got=%0d/%0d exp=%0d/%0d", i, err_count, err_count2, exp8[i], exp2[i]); end
        end
        checks++; if (parity_err2 !== 1'b1) begin failures++; $display("FAIL sat_parity_err got=%b exp=1", parity_err2); end
        send_frame(1'b0, 4'b0001, 1'b0, 1'b1, 1'b1);
        checks++; if (err_count !== 8'd0 || err_count2 !== 2'd0) begin failures++; $display("FAIL clr_wins got=%0d/%0d exp=0/0", err_count, err_count2); end
        checks++; if (data_valid2 !== 1'b1 || parity_err2 !== 1'b1) begin failures++; $display("FAIL clr_frame valid=%b perr=%b exp=1/1", data_valid2, parity_err2); end
        send_frame(1'b0, 4'b0001, 1'b0, 1'b1, 1'b0);
        checks++; if (err_count !== 8'd1 || err_count2 !== 2'd1) begin failures++; $display("FAIL clr_then_inc got=%0d/%0d exp=1/1", err_count, err_count2); end
        drive(1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_even_good();
        test_odd_parity_err();
        test_frame_err();
        test_gating_mode();
        test_back_to_back();
        test_reset_midframe();
        test_saturation_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
